filter_sample_sequencer: RTL and testbench

Initiator/host side of the filter-core START_FLAG/DATA_VALID handshake. It accepts samples from a valid/ready source and holds each sample on the core input. It fires a one-cycle start, tracks the core's busy/done sequence, and captures each result into an output FIFO drained through valid/ready. It also supervises the core: it counts lost samples and recovers a hung core through a timeout.

---
 rtl/filter_sample_sequencer_if.sv | 22 ++
 rtl/filter_sample_sequencer.sv | 153 +++++++++++++++
 tb/tb_filter_sample_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_sample_sequencer_if.sv
// Sample-in / result-out stream bundle of the filter sample sequencer.
// The master modport is the sequencer side; slave is the source/sink environment.
interface filter_sample_sequencer_if #(
  parameter int unsigned BITWIDTH_DATA = 12
);
  logic [BITWIDTH_DATA-1:0] S_DATA;
  logic                     S_VALID;
  logic                     S_READY;
  logic [BITWIDTH_DATA-1:0] M_DATA;
  logic                     M_VALID;
  logic                     M_READY;

  modport master (
    input  S_DATA, S_VALID, M_READY,
    output S_READY, M_DATA, M_VALID
  );

  modport slave (
    output S_DATA, S_VALID, M_READY,
    input  S_READY, M_DATA, M_VALID
  );
endinterface

// File: rtl/filter_sample_sequencer.sv
// Host side of the filter-core start/valid handshake: feeds samples, buffers results in a FIFO,
// counts lost samples and recovers a hung core after a timeout.
module filter_sample_sequencer #(
  parameter int unsigned BITWIDTH_DATA = 12,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYC   = 1023
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     EN,
  filter_sample_sequencer_if.master bus,
  output logic                     FLT_EN,
  output logic                     FLT_START,
  output logic [BITWIDTH_DATA-1:0] FLT_DIN,
  input  logic [BITWIDTH_DATA-1:0] FLT_DOUT,
  input  logic                     FLT_VALID,
  output logic [7:0]               DROP_CNT,
  output logic                     TIMEOUT_ERR
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, RECOVER} state_t;

  state_t                   state_q, state_d;
  logic                     accept, push_req, timeout, tmo_clr, tmo_inc, tmo_hit;
  logic [TW-1:0]            tmo_cnt;
  logic                     flt_start_q;
  logic [BITWIDTH_DATA-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr, rd_ptr_d;
  logic [CW-1:0]            count, count_d;
  logic [BITWIDTH_DATA-1:0] m_data_q, m_data_d;
  logic                     m_valid_q, pop, push, full;
  logic                     drop_src, drop_fifo;
  logic [1:0]               drop_inc;
  logic [8:0]               drop_sum;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle strobes; EN low abandons any sequence in flight.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    push_req = 1'b0;
    timeout  = 1'b0;
    tmo_clr  = 1'b0;
    tmo_inc  = 1'b0;
    if (!EN) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.S_VALID) begin
            accept  = 1'b1;
            state_d = START;
          end
        end
        START: begin
          tmo_clr = 1'b1;
          state_d = WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!FLT_VALID) begin
            state_d = WAIT_DONE;
          end else if (tmo_hit) begin
            timeout = 1'b1;
            state_d = RECOVER;
          end else begin
            tmo_inc = 1'b1;
          end
        end
        WAIT_DONE: begin
          if (FLT_VALID) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end else if (tmo_hit) begin
            timeout = 1'b1;
            state_d = RECOVER;
          end else begin
            tmo_inc = 1'b1;
          end
        end
        RECOVER: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Reset is folded in so both flags read low while nRST is held, regardless of EN.
  assign bus.S_READY = EN && nRST && (state_q == IDLE);
  assign FLT_EN      = EN && nRST && (state_q != RECOVER);
  assign FLT_START   = flt_start_q;

  // Output FIFO with a registered head; a push into an empty FIFO forwards straight into the head.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = m_valid_q && bus.M_READY;
  assign push      = push_req && (!full || pop);
  assign drop_fifo = push_req && full && !pop;
  assign count_d   = count + CW'(push) - CW'(pop);
  assign rd_ptr_d  = rd_ptr + PW'(pop);

  always_comb begin
    m_data_d = m_data_q;
    if (count_d != '0) begin
      m_data_d = (push && (wr_ptr == rd_ptr_d)) ? FLT_DOUT : mem[rd_ptr_d];
    end
  end

  assign bus.M_DATA  = m_data_q;
  assign bus.M_VALID = m_valid_q;

  // Up to two loss events per cycle: a stalled source beat plus a FIFO overflow or a timeout.
  assign drop_src = bus.S_VALID && EN && (state_q != IDLE);
  assign drop_inc = 2'(drop_src) + 2'(drop_fifo) + 2'(timeout);
  assign drop_sum = 9'(DROP_CNT) + 9'(drop_inc);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flt_start_q <= 1'b0;
      FLT_DIN     <= '0;
      tmo_cnt     <= '0;
      TIMEOUT_ERR <= 1'b0;
      DROP_CNT    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      flt_start_q <= (state_d == START);
      if (accept) FLT_DIN <= bus.S_DATA;
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);
      if (timeout) TIMEOUT_ERR <= 1'b1;
      DROP_CNT <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      if (push) begin
        mem[wr_ptr] <= FLT_DOUT;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      rd_ptr    <= rd_ptr_d;
      count     <= count_d;
      m_data_q  <= m_data_d;
      m_valid_q <= (count_d != '0);
    end
  end
endmodule

// File: tb/tb_filter_sample_sequencer.sv
// Directed bench for filter_sample_sequencer with a LENGTH=4 behavioural filter core.
module tb_filter_sample_sequencer;
  localparam int unsigned W      = 12;
  localparam int unsigned LENGTH = 4;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         EN;
  logic         flt_en, flt_start, flt_valid, timeout_err;
  logic [W-1:0] flt_din, flt_dout;
  logic [7:0]   drop_cnt;
  logic         stuck;
  logic         core_busy;
  logic [2:0]   core_cnt;
  logic [W-1:0] core_din;
  int           checks = 0;
  int           errors = 0;
  int           start_cnt = 0;
  int           s0;
  logic [W-1:0] beats [$];
  logic [W-1:0] last;

  filter_sample_sequencer_if #(.BITWIDTH_DATA(W)) sif ();

  filter_sample_sequencer #(.BITWIDTH_DATA(W), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .nRST(nRST), .EN(EN), .bus(sif),
    .FLT_EN(flt_en), .FLT_START(flt_start), .FLT_DIN(flt_din), .FLT_DOUT(flt_dout),
    .FLT_VALID(flt_valid), .DROP_CNT(drop_cnt), .TIMEOUT_ERR(timeout_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] model(input logic [W-1:0] x);
    return W'(32'(x) * 32'd3 + 32'd1);
  endfunction

  // Reference core: busy for LENGTH cycles after start; in stuck mode it ignores start and stays valid.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      core_busy <= 1'b0; core_cnt <= '0; core_din <= '0; flt_dout <= '0;
    end else if (!flt_en) begin
      core_busy <= 1'b0;
    end else if (flt_start && !stuck) begin
      core_busy <= 1'b1; core_cnt <= 3'(LENGTH - 1); core_din <= flt_din;
    end else if (core_busy) begin
      if (core_cnt == 3'd0) begin
        core_busy <= 1'b0; flt_dout <= model(core_din);
      end else begin
        core_cnt <= core_cnt - 3'd1;
      end
    end
  end
  assign flt_valid = stuck ? 1'b1 : (!core_busy && flt_en);

  always @(negedge CLK) if (flt_start) start_cnt <= start_cnt + 1;
  always @(posedge CLK) if (nRST && sif.M_VALID && sif.M_READY) beats.push_back(sif.M_DATA);

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sif.S_READY !== 1'b1 && n < 60) begin cyc(); n++; end
    chk("wait_idle", 32'(sif.S_READY), 32'd1);
  endtask

  task automatic send(input logic [W-1:0] d);
    wait_idle();
    sif.S_DATA = d; sif.S_VALID = 1'b1;
    cyc();
    sif.S_VALID = 1'b0;
  endtask

  task automatic last_beat(input string tag, input int n, input logic [W-1:0] exp);
    chk({tag, "_count"}, 32'(beats.size()), 32'(n));
    last = (beats.size() > 0) ? beats[beats.size() - 1] : 'x;
    chk({tag, "_data"}, 32'(last), 32'(exp));
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; EN = 1'b0; stuck = 1'b0;
    sif.S_DATA = '0; sif.S_VALID = 1'b0; sif.M_READY = 1'b0;
    cyc(); cyc();
    chk("rst_s_ready", 32'(sif.S_READY), 32'd0);
    chk("rst_start", 32'(flt_start), 32'd0);
    chk("rst_din", 32'(flt_din), 32'd0);
    chk("rst_flt_en", 32'(flt_en), 32'd0);
    chk("rst_m_valid", 32'(sif.M_VALID), 32'd0);
    chk("rst_m_data", 32'(sif.M_DATA), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);

    // Single sample through the core
    nRST = 1'b1; EN = 1'b1; sif.M_READY = 1'b1;
    cyc();
    chk("t1_ready", 32'(sif.S_READY), 32'd1);
    chk("t1_flt_en", 32'(flt_en), 32'd1);
    s0 = start_cnt;
    send(12'h100);
    chk("t1_start_hi", 32'(flt_start), 32'd1);
    chk("t1_din", 32'(flt_din), 32'h100);
    cyc();
    chk("t1_start_lo", 32'(flt_start), 32'd0);
    wait_idle();
    cyc(); cyc();
    chk("t1_starts", 32'(start_cnt - s0), 32'd1);
    last_beat("t1_beat", 1, 12'h301);
    chk("t1_m_valid", 32'(sif.M_VALID), 32'd0);
    chk("t1_din_hold", 32'(flt_din), 32'h100);
    chk("t1_drop", 32'(drop_cnt), 32'd0);

    // Five results into a 4-deep FIFO with the sink stalled
    sif.M_READY = 1'b0;
    for (int i = 1; i <= 5; i++) begin send(W'(i)); wait_idle(); end
    cyc();
    chk("t2_drop", 32'(drop_cnt), 32'd1);
    chk("t2_m_valid", 32'(sif.M_VALID), 32'd1);
    chk("t2_head", 32'(sif.M_DATA), 32'h004);
    sif.M_READY = 1'b1;
    repeat (6) cyc();
    chk("t2_b1", 32'(beats[1]), 32'h004);
    chk("t2_b2", 32'(beats[2]), 32'h007);
    chk("t2_b3", 32'(beats[3]), 32'h00A);
    last_beat("t2_b4", 5, 12'h00D);
    chk("t2_empty", 32'(sif.M_VALID), 32'd0);

    // Full FIFO: push and pop on the same edge
    sif.M_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin send(W'(12'h010 + i)); wait_idle(); end
    send(12'h020);
    for (int n = 0; n < 20 && flt_valid !== 1'b0; n++) cyc();
    for (int n = 0; n < 20 && flt_valid !== 1'b1; n++) cyc();
    sif.M_READY = 1'b1;
    cyc();
    sif.M_READY = 1'b0;
    chk("t3_head", 32'(sif.M_DATA), 32'h034);
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    last_beat("t3_popped", 6, 12'h031);
    sif.M_READY = 1'b1;
    repeat (6) cyc();
    chk("t3_b7", 32'(beats[7]), 32'h037);
    chk("t3_b8", 32'(beats[8]), 32'h03A);
    last_beat("t3_new_last", 10, 12'h061);

    // Hung core: FLT_VALID never drops
    stuck = 1'b1;
    send(12'h055);
    repeat (16) cyc();
    chk("t4_tmo_pre", 32'(timeout_err), 32'd0);
    chk("t4_en_pre", 32'(flt_en), 32'd1);
    cyc();
    chk("t4_tmo", 32'(timeout_err), 32'd1);
    chk("t4_en_low", 32'(flt_en), 32'd0);
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    chk("t4_ready_rec", 32'(sif.S_READY), 32'd0);
    cyc();
    chk("t4_en_back", 32'(flt_en), 32'd1);
    chk("t4_ready", 32'(sif.S_READY), 32'd1);
    chk("t4_tmo_sticky", 32'(timeout_err), 32'd1);
    stuck = 1'b0;

    // Non-stallable source: 7-cycle sequence, 6 lost beats each
    s0 = start_cnt;
    sif.S_DATA = 12'h200; sif.S_VALID = 1'b1;
    repeat (21) cyc();
    chk("t5_starts", 32'(start_cnt - s0), 32'd3);
    chk("t5_drop", 32'(drop_cnt), 32'd20);
    chk("t5_ready", 32'(sif.S_READY), 32'd1);
    repeat (280) cyc();
    sif.S_VALID = 1'b0;
    chk("t5_drop_sat", 32'(drop_cnt), 32'd255);
    cyc(); cyc();
    chk("t5_starts_all", 32'(start_cnt - s0), 32'd43);
    last_beat("t5_beats", 53, 12'h601);
    chk("t5_drop_hold", 32'(drop_cnt), 32'd255);

    // Reset while waiting for the core
    sif.M_READY = 1'b0;
    send(12'h033);
    cyc(); cyc();
    nRST = 1'b0;
    #1;
    chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
    chk("t6_rst_tmo", 32'(timeout_err), 32'd0);
    chk("t6_rst_din", 32'(flt_din), 32'd0);
    chk("t6_rst_en", 32'(flt_en), 32'd0);
    chk("t6_rst_ready", 32'(sif.S_READY), 32'd0);
    chk("t6_rst_m_data", 32'(sif.M_DATA), 32'd0);
    chk("t6_rst_m_valid", 32'(sif.M_VALID), 32'd0);
    cyc();
    nRST = 1'b1;
    repeat (8) cyc();
    chk("t6_no_push", 32'(sif.M_VALID), 32'd0);
    chk("t6_idle", 32'(sif.S_READY), 32'd1);

    // EN dropped mid-sequence keeps the FIFO
    send(12'h044);
    wait_idle();
    cyc();
    chk("t6_head", 32'(sif.M_DATA), 32'h0CD);
    stuck = 1'b1;
    send(12'h066);
    repeat (3) cyc();
    EN = 1'b0;
    #1;
    chk("t6_en_flt_en", 32'(flt_en), 32'd0);
    chk("t6_en_ready", 32'(sif.S_READY), 32'd0);
    cyc();
    chk("t6_en_start", 32'(flt_start), 32'd0);
    chk("t6_en_m_valid", 32'(sif.M_VALID), 32'd1);
    chk("t6_en_m_data", 32'(sif.M_DATA), 32'h0CD);
    chk("t6_en_drop", 32'(drop_cnt), 32'd0);
    chk("t6_en_tmo", 32'(timeout_err), 32'd0);
    chk("t6_en_din", 32'(flt_din), 32'h066);
    sif.M_READY = 1'b1;
    cyc(); cyc();
    last_beat("t6_drain", 54, 12'h0CD);
    chk("t6_drained", 32'(sif.M_VALID), 32'd0);
    EN = 1'b1; stuck = 1'b0;
    cyc();
    chk("t6_en_idle", 32'(sif.S_READY), 32'd1);
    send(12'h007);
    wait_idle();
    cyc(); cyc();
    last_beat("t6_resume", 55, 12'h016);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
